// File: rtl/trn_pkg.sv
// Shared TRN RX definitions: TLP header field positions, parser states and
// the DW FIFO entry layout.
package trn_pkg;

  localparam logic [6:0] FMT_TYPE_MWR32 = 7'h40;
  localparam logic [6:0] FMT_TYPE_MWR64 = 7'h60;

  // Header DW0 fields as seen on trn_rd of the SOF beat
  localparam int unsigned FMT_TYPE_HI = 62;
  localparam int unsigned FMT_TYPE_LO = 56;
  localparam int unsigned EP_BIT      = 46;
  localparam int unsigned LEN_HI      = 41;
  localparam int unsigned LEN_LO      = 32;
  // Header DW1 fields (lower half of the SOF beat)
  localparam int unsigned LBE_HI      = 7;
  localparam int unsigned LBE_LO      = 4;
  localparam int unsigned FBE_HI      = 3;
  localparam int unsigned FBE_LO      = 0;

  localparam int unsigned LEN_CNT_W   = 11;
  localparam int unsigned FIFO_DEPTH  = 4;
  localparam int unsigned FIFO_PTR_W  = 2;
  localparam int unsigned FIFO_CNT_W  = 3;
  localparam int unsigned DW_ENT_W    = 38;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR2 = 2'd1,
    ST_DATA = 2'd2,
    ST_DROP = 2'd3
  } rx_state_e;

  typedef struct packed {
    logic        first;
    logic        last;
    logic [3:0]  be;
    logic [31:0] data;
  } dw_ent_t;

  // TLP payload is big-endian on the wire; the fabric wants TLP byte 0 in [7:0]
  function automatic logic [31:0] dw_swap(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

endpackage

// File: rtl/trn_rx_dw_fifo.sv
// 4-entry payload DW FIFO: up to two pushes and one pop per cycle, plus the
// free count that will hold after the current cycle.
module trn_rx_dw_fifo
  import trn_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push0,
  input  logic                  push1,
  input  dw_ent_t               din0,
  input  dw_ent_t               din1,
  input  logic                  pop,
  output dw_ent_t               head_c,
  output logic                  nempty_c,
  output logic [FIFO_CNT_W-1:0] free_nxt_c
);

  dw_ent_t                 mem_q [FIFO_DEPTH];
  logic [FIFO_PTR_W-1:0]   wp_q, wp_d, rp_q, rp_d;
  logic [FIFO_CNT_W-1:0]   cnt_q, cnt_d;

  // push1 is only ever used together with push0
  always_comb begin
    wp_d  = wp_q + FIFO_PTR_W'(push0) + FIFO_PTR_W'(push1);
    rp_d  = rp_q + FIFO_PTR_W'(pop);
    cnt_d = cnt_q + FIFO_CNT_W'(push0) + FIFO_CNT_W'(push1) - FIFO_CNT_W'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push0) mem_q[wp_q] <= din0;
    if (push1) mem_q[wp_q + FIFO_PTR_W'(1)] <= din1;
  end

  assign head_c     = mem_q[rp_q];
  assign nempty_c   = (cnt_q != '0);
  assign free_nxt_c = FIFO_CNT_W'(FIFO_DEPTH) - cnt_d;

endmodule

// File: rtl/trn_rx_mwr_sink.sv
// TRN RX memory-write sink: parses MWr32/MWr64 TLPs on enabled BARs into DW writes.
// Optional TLP statistics counters when TRN_RX_STATS_EN is defined.
module trn_rx_mwr_sink
  import trn_pkg::*;
#(
  parameter int unsigned ADDR_W   = 10,
  parameter logic [6:0]  BAR_MASK = 7'h01
) (
  input  logic              trn_clk,
  input  logic              trn_reset_n,
  input  logic [63:0]       trn_rd,
  input  logic              trn_rrem_n,
  input  logic              trn_rsof_n,
  input  logic              trn_reof_n,
  input  logic              trn_rsrc_rdy_n,
  input  logic              trn_rsrc_dsc_n,
  input  logic              trn_rerrfwd_n,
  input  logic [6:0]        trn_rbar_hit_n,
  output logic              trn_rdst_rdy_n,
  output logic              trn_rnp_ok_n,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic [3:0]        wr_be,
  output logic              err_malformed
`ifdef TRN_RX_STATS_EN
  ,
  output logic [15:0]       stat_acc,
  output logic [15:0]       stat_drop,
  output logic [15:0]       stat_err
`endif
);

  localparam int unsigned A32_HI = 32 + ADDR_W + 1;

  rx_state_e              state_q, state_d;
  logic [LEN_CNT_W-1:0]   rem_q, rem_d, rem_v, hdr_len_c;
  logic                   first_q, first_d, first_v, over_v;
  logic [3:0]             fbe_q, fbe_d, lbe_q, lbe_d;
  logic                   is64_q, is64_d;
  logic [ADDR_W-1:0]      saddr_q, saddr_d, start_v;
  logic                   err_q, err_d;
  logic                   rdst_rdy_n_q, rdst_rdy_n_d;
  logic                   beat_c, sof_c, eof_c, bad_c, is_mwr_c, accept_c, acc_c, drop_c;
  logic [1:0]             n_dw;
  logic [31:0]            dw_v   [2];
  logic                   push_v [2];
  dw_ent_t                ent_v  [2];

  dw_ent_t                head_c;
  logic                   nempty_c, load_c;
  logic [FIFO_CNT_W-1:0]  free_nxt_c;
  logic [ADDR_W-1:0]      ring_q [FIFO_DEPTH];
  logic [FIFO_PTR_W-1:0]  ring_wp_q, ring_wp_d, ring_rp_q, ring_rp_d;
  logic                   ring_we_c;
  logic                   wr_valid_q, wr_valid_d;
  logic [ADDR_W-1:0]      wr_addr_q, wr_addr_d;
  logic [31:0]            wr_data_q, wr_data_d;
  logic [3:0]             wr_be_q, wr_be_d;
  logic                   unused_last_c;

  assign beat_c    = !trn_rsrc_rdy_n && !rdst_rdy_n_q;
  assign sof_c     = !trn_rsof_n;
  assign eof_c     = !trn_reof_n;
  assign bad_c     = !trn_rsrc_dsc_n || !trn_rerrfwd_n;
  assign is_mwr_c  = (trn_rd[FMT_TYPE_HI:FMT_TYPE_LO] == FMT_TYPE_MWR32) ||
                     (trn_rd[FMT_TYPE_HI:FMT_TYPE_LO] == FMT_TYPE_MWR64);
  assign accept_c  = is_mwr_c && (|(~trn_rbar_hit_n & BAR_MASK)) && !trn_rd[EP_BIT];
  assign hdr_len_c = (trn_rd[LEN_HI:LEN_LO] == 10'd0) ? LEN_CNT_W'(1024)
                                                      : LEN_CNT_W'(trn_rd[LEN_HI:LEN_LO]);

  // Parser FSM: header decode, payload push with byte enables, length checking
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    first_d   = first_q;
    fbe_d     = fbe_q;
    lbe_d     = lbe_q;
    is64_d    = is64_q;
    saddr_d   = saddr_q;
    err_d     = 1'b0;
    acc_c     = 1'b0;
    drop_c    = 1'b0;
    n_dw      = 2'd0;
    dw_v[0]   = trn_rd[63:32];
    dw_v[1]   = trn_rd[31:0];
    push_v[0] = 1'b0;
    push_v[1] = 1'b0;
    ent_v[0]  = '0;
    ent_v[1]  = '0;
    rem_v     = rem_q;
    first_v   = first_q;
    over_v    = 1'b0;
    start_v   = saddr_q;
    if (beat_c) begin
      if (sof_c) begin
        err_d = (state_q != ST_IDLE);
        if (accept_c) begin
          acc_c   = 1'b1;
          rem_d   = hdr_len_c;
          first_d = 1'b1;
          fbe_d   = trn_rd[FBE_HI:FBE_LO];
          lbe_d   = trn_rd[LBE_HI:LBE_LO];
          is64_d  = (trn_rd[FMT_TYPE_HI:FMT_TYPE_LO] == FMT_TYPE_MWR64);
          if (eof_c) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_HDR2;
          end
        end else begin
          drop_c  = 1'b1;
          state_d = eof_c ? ST_IDLE : ST_DROP;
        end
      end else begin
        case (state_q)
          ST_HDR2, ST_DATA: begin
            if (bad_c) begin
              err_d   = 1'b1;
              state_d = eof_c ? ST_IDLE : ST_DROP;
            end else if (state_q == ST_HDR2 && is64_q) begin
              saddr_d = trn_rd[ADDR_W+1:2];
              if (trn_rd[63:32] != 32'd0) begin
                drop_c  = 1'b1;
                state_d = eof_c ? ST_IDLE : ST_DROP;
              end else if (eof_c) begin
                err_d   = 1'b1;
                state_d = ST_IDLE;
              end else begin
                state_d = ST_DATA;
              end
            end else begin
              if (state_q == ST_HDR2) begin
                start_v = trn_rd[A32_HI:34];
                saddr_d = start_v;
                dw_v[0] = trn_rd[31:0];
                n_dw    = (eof_c && trn_rrem_n) ? 2'd0 : 2'd1;
              end else begin
                n_dw    = (eof_c && trn_rrem_n) ? 2'd1 : 2'd2;
              end
              for (int k = 0; k < 2; k++) begin
                if (2'(k) < n_dw) begin
                  if (rem_v == '0) begin
                    over_v = 1'b1;
                  end else begin
                    push_v[k]      = 1'b1;
                    ent_v[k].data  = dw_swap(dw_v[k]);
                    ent_v[k].be    = first_v ? fbe_q :
                                     ((rem_v == LEN_CNT_W'(1)) ? lbe_q : 4'hf);
                    ent_v[k].first = first_v;
                    ent_v[k].last  = (rem_v == LEN_CNT_W'(1));
                    rem_v          = rem_v - LEN_CNT_W'(1);
                    first_v        = 1'b0;
                  end
                end
              end
              rem_d   = rem_v;
              first_d = first_v;
              if (over_v) begin
                err_d   = 1'b1;
                state_d = eof_c ? ST_IDLE : ST_DROP;
              end else if (eof_c) begin
                err_d   = (rem_v != '0);
                state_d = ST_IDLE;
              end else begin
                state_d = ST_DATA;
              end
            end
          end
          ST_DROP: if (eof_c) state_d = ST_IDLE;
          default: ;
        endcase
      end
    end
  end

  // The first DW of a TLP is always pushed on slot 0; its start address is queued alongside
  assign ring_we_c     = push_v[0] && ent_v[0].first;
  assign load_c        = nempty_c && (!wr_valid_q || wr_ready);
  assign unused_last_c = head_c.last;

  // Output register: reloads from the FIFO head whenever empty or accepted
  always_comb begin
    wr_valid_d   = wr_valid_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    wr_be_d      = wr_be_q;
    ring_wp_d    = ring_wp_q + FIFO_PTR_W'(ring_we_c);
    ring_rp_d    = ring_rp_q;
    rdst_rdy_n_d = (free_nxt_c < FIFO_CNT_W'(2));
    if (load_c) begin
      wr_valid_d = 1'b1;
      wr_data_d  = head_c.data;
      wr_be_d    = head_c.be;
      wr_addr_d  = head_c.first ? ring_q[ring_rp_q] : wr_addr_q + ADDR_W'(1);
      ring_rp_d  = ring_rp_q + FIFO_PTR_W'(head_c.first);
    end else if (wr_ready) begin
      wr_valid_d = 1'b0;
    end
  end

  always_ff @(posedge trn_clk or negedge trn_reset_n) begin
    if (!trn_reset_n) begin
      state_q      <= ST_IDLE;
      rem_q        <= '0;
      first_q      <= 1'b0;
      fbe_q        <= '0;
      lbe_q        <= '0;
      is64_q       <= 1'b0;
      saddr_q      <= '0;
      err_q        <= 1'b0;
      rdst_rdy_n_q <= 1'b1;
      ring_wp_q    <= '0;
      ring_rp_q    <= '0;
      wr_valid_q   <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      wr_be_q      <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) ring_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      rem_q        <= rem_d;
      first_q      <= first_d;
      fbe_q        <= fbe_d;
      lbe_q        <= lbe_d;
      is64_q       <= is64_d;
      saddr_q      <= saddr_d;
      err_q        <= err_d;
      rdst_rdy_n_q <= rdst_rdy_n_d;
      ring_wp_q    <= ring_wp_d;
      ring_rp_q    <= ring_rp_d;
      wr_valid_q   <= wr_valid_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      wr_be_q      <= wr_be_d;
      if (ring_we_c) ring_q[ring_wp_q] <= start_v;
    end
  end

  trn_rx_dw_fifo u_fifo (
    .clk        (trn_clk),
    .rst_n      (trn_reset_n),
    .push0      (push_v[0]),
    .push1      (push_v[1]),
    .din0       (ent_v[0]),
    .din1       (ent_v[1]),
    .pop        (load_c),
    .head_c     (head_c),
    .nempty_c   (nempty_c),
    .free_nxt_c (free_nxt_c)
  );

  assign trn_rdst_rdy_n = rdst_rdy_n_q;
  assign trn_rnp_ok_n   = 1'b0;
  assign wr_valid       = wr_valid_q;
  assign wr_addr        = wr_addr_q;
  assign wr_data        = wr_data_q;
  assign wr_be          = wr_be_q;
  assign err_malformed  = err_q;

`ifdef TRN_RX_STATS_EN
  logic [15:0] stat_acc_q, stat_drop_q, stat_err_q;

  // Saturating TLP statistics
  always_ff @(posedge trn_clk or negedge trn_reset_n) begin
    if (!trn_reset_n) begin
      stat_acc_q  <= '0;
      stat_drop_q <= '0;
      stat_err_q  <= '0;
    end else begin
      if (acc_c  && stat_acc_q  != 16'hffff) stat_acc_q  <= stat_acc_q  + 16'd1;
      if (drop_c && stat_drop_q != 16'hffff) stat_drop_q <= stat_drop_q + 16'd1;
      if (err_d  && stat_err_q  != 16'hffff) stat_err_q  <= stat_err_q  + 16'd1;
    end
  end

  assign stat_acc  = stat_acc_q;
  assign stat_drop = stat_drop_q;
  assign stat_err  = stat_err_q;
`endif

endmodule
